// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch responder.
`timescale 1ns/1ps
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam int          TIMEOUT_W = 8;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

endpackage

// File: rtl/fetch_timeout_counter.sv
// Bus-wait cycle counter: cleared while idle, counts while enabled, saturates at TIMEOUT-1.
`timescale 1ns/1ps
module fetch_timeout_counter
  import fetch_pkg::*;
#(
  parameter int TIMEOUT = 255
)
(
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  localparam logic [TIMEOUT_W-1:0] LAST_COUNT = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  assign terminal_o = (count_q == LAST_COUNT);

  // NOTE: default assignment first so every path drives count_d and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !terminal_o) begin
      count_d = count_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_responder.sv
// Memory-side end of the instruction fetch handshake: single-word bus reads with timeout/flush handling.
// Optional last-line buffer enabled by defining FETCH_LAST_LINE_EN.
`timescale 1ns/1ps
module instr_fetch_responder
  import fetch_pkg::*;
#(
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
)
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_request,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic [31:0] instruction,
  output logic        in_en,
  output logic        fetch_fault,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        mem_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  mem_addr_q, mem_addr_d;
  logic         mem_read_q, mem_read_d;
  logic         in_en_q, in_en_d;
  logic         fault_q, fault_d;
  logic         busy_q, busy_d;
  logic         terminal;
  logic         buf_hit;
  logic [31:0]  buf_data;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (state_q == IDLE),
    .enable_i   ((state_q == WAIT) || (state_q == DROP)),
    .terminal_o (terminal)
  );

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    mem_addr_d = mem_addr_q;
    mem_read_d = mem_read_q;
    in_en_d    = 1'b0;
    fault_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The cycle showing in_en still sees the old request, so acceptance waits one cycle.
        if (i_request && !flush && !in_en_q) begin
          if (pc_in[1:0] != 2'b00) begin
            state_d = FAULT;
            instr_d = NOP_INSTR;
            in_en_d = 1'b1;
            fault_d = 1'b1;
          end else if (buf_hit) begin
            instr_d = buf_data;
            in_en_d = 1'b1;
          end else begin
            state_d    = WAIT;
            mem_addr_d = pc_in;
            mem_read_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_read_d = 1'b0;
          if (!flush) begin
            in_en_d = 1'b1;
            fault_d = mem_err;
            instr_d = mem_err ? NOP_INSTR : mem_rdata;
          end
        end else if (flush) begin
          // The read cannot be cancelled; keep strobing until it completes or times out.
          if (terminal) begin
            state_d    = IDLE;
            mem_read_d = 1'b0;
          end else begin
            state_d = DROP;
          end
        end else if (terminal) begin
          state_d    = IDLE;
          mem_read_d = 1'b0;
          instr_d    = NOP_INSTR;
          in_en_d    = 1'b1;
          fault_d    = 1'b1;
        end
      end
      DROP: begin
        if (mem_ack || terminal) begin
          state_d    = IDLE;
          mem_read_d = 1'b0;
        end
      end
      FAULT: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        mem_read_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      instr_q    <= NOP_INSTR;
      mem_addr_q <= '0;
      mem_read_q <= 1'b0;
      in_en_q    <= 1'b0;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      mem_addr_q <= mem_addr_d;
      mem_read_q <= mem_read_d;
      in_en_q    <= in_en_d;
      fault_q    <= fault_d;
      busy_q     <= busy_d;
    end
  end

`ifdef FETCH_LAST_LINE_EN
  logic        buf_valid_q;
  logic [31:0] buf_addr_q;
  logic [31:0] buf_data_q;

  assign buf_hit  = buf_valid_q && (buf_addr_q == pc_in);
  assign buf_data = buf_data_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else if (flush || fault_d) begin
      buf_valid_q <= 1'b0;
    end else if ((state_q == WAIT) && mem_ack && !mem_err) begin
      buf_valid_q <= 1'b1;
      buf_addr_q  <= mem_addr_q;
      buf_data_q  <= mem_rdata;
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_data = NOP_INSTR;
`endif

  assign instruction = instr_q;
  assign in_en       = in_en_q;
  assign fetch_fault = fault_q;
  assign busy        = busy_q;
  assign mem_addr    = mem_addr_q;
  assign mem_read    = mem_read_q;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Scoreboard bench for instr_fetch_responder (TIMEOUT=8); covers FETCH_LAST_LINE_EN when defined.
`timescale 1ns/1ps
module tb_instr_fetch_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        i_request = 1'b0;
  logic [31:0] pc_in = '0;
  logic        flush = 1'b0;
  logic [31:0] instruction;
  logic        in_en;
  logic        fetch_fault;
  logic        busy;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        mem_err = 1'b0;

  int   compared = 0;
  int   mismatched = 0;
  int   in_en_cnt = 0;
  exp_t exp_q[$];

  instr_fetch_responder #(.TIMEOUT(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_request   (i_request),
    .pc_in       (pc_in),
    .flush       (flush),
    .instruction (instruction),
    .in_en       (in_en),
    .fetch_fault (fetch_fault),
    .busy        (busy),
    .mem_addr    (mem_addr),
    .mem_read    (mem_read),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .mem_err     (mem_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (in_en === 1'b1) in_en_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic respond(input int delay, input logic [31:0] data, input logic err);
    repeat (delay) step();
    mem_ack   = 1'b1;
    mem_rdata = data;
    mem_err   = err;
    step();
    mem_ack   = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic pop_exp(output exp_t e);
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_empty: got in_en with no expected entry");
      e = '{32'hx, 1'bx};
    end else begin
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    compared++; if (instruction !== NOP) begin mismatched++; $display("FAIL reset_instr: got %h expected %h", instruction, NOP); end
    compared++; if (in_en !== 1'b0) begin mismatched++; $display("FAIL reset_in_en: got %b expected 0", in_en); end
    compared++; if (fetch_fault !== 1'b0) begin mismatched++; $display("FAIL reset_fault: got %b expected 0", fetch_fault); end
    compared++; if (mem_read !== 1'b0) begin mismatched++; $display("FAIL reset_mem_read: got %b expected 0", mem_read); end
    compared++; if (mem_addr !== 32'h0) begin mismatched++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic_fetch();
    exp_t e;
    i_request = 1'b1;
    pc_in     = 32'h100;
    exp_q.push_back('{32'h0050_0093, 1'b0});
    step();
    compared++; if (mem_read !== 1'b1) begin mismatched++; $display("FAIL basic_mem_read: got %b expected 1", mem_read); end
    compared++; if (mem_addr !== 32'h100) begin mismatched++; $display("FAIL basic_mem_addr: got %h expected 100", mem_addr); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL basic_busy_high: got %b expected 1", busy); end
    respond(3, 32'h0050_0093, 1'b0);
    compared++; if (in_en !== 1'b1) begin mismatched++; $display("FAIL basic_in_en: got %b expected 1", in_en); end
    pop_exp(e);
    compared++; if (instruction !== e.instr) begin mismatched++; $display("FAIL basic_instr: got %h expected %h", instruction, e.instr); end
    compared++; if (fetch_fault !== e.fault) begin mismatched++; $display("FAIL basic_fault: got %b expected %b", fetch_fault, e.fault); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_low: got %b expected 0", busy); end
    i_request = 1'b0;
    step();
    compared++; if (in_en !== 1'b0) begin mismatched++; $display("FAIL basic_single_pulse: got %b expected 0", in_en); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_misaligned();
    exp_t e;
    i_request = 1'b1;
    pc_in     = 32'h102;
    exp_q.push_back('{NOP, 1'b1});
    step();
    compared++; if (in_en !== 1'b1) begin mismatched++; $display("FAIL misalign_in_en: got %b expected 1", in_en); end
    compared++; if (mem_read !== 1'b0) begin mismatched++; $display("FAIL misalign_mem_read: got %b expected 0", mem_read); end
    pop_exp(e);
    compared++; if (instruction !== e.instr) begin mismatched++; $display("FAIL misalign_instr: got %h expected %h", instruction, e.instr); end
    compared++; if (fetch_fault !== e.fault) begin mismatched++; $display("FAIL misalign_fault: got %b expected %b", fetch_fault, e.fault); end
    i_request = 1'b0;
    step();
    compared++; if ({in_en, fetch_fault} !== 2'b00) begin mismatched++; $display("FAIL misalign_pulse_end: got %b expected 00", {in_en, fetch_fault}); end
  endtask

  task automatic test_timeout();
    exp_t e;
    int   n = 0;
    i_request = 1'b1;
    pc_in     = 32'h300;
    exp_q.push_back('{NOP, 1'b1});
    step();
    while (mem_read === 1'b1 && n < 20) begin
      n++;
      step();
    end
    compared++; if (n !== 8) begin mismatched++; $display("FAIL timeout_read_cycles: got %0d expected 8", n); end
    compared++; if (in_en !== 1'b1) begin mismatched++; $display("FAIL timeout_in_en: got %b expected 1", in_en); end
    pop_exp(e);
    compared++; if (instruction !== e.instr) begin mismatched++; $display("FAIL timeout_instr: got %h expected %h", instruction, e.instr); end
    compared++; if (fetch_fault !== e.fault) begin mismatched++; $display("FAIL timeout_fault: got %b expected %b", fetch_fault, e.fault); end
    i_request = 1'b0;
    step();
  endtask

  task automatic test_flush();
    exp_t e;
    int   base = in_en_cnt;
    i_request = 1'b1;
    pc_in     = 32'h180;
    step();
    step();
    flush     = 1'b1;
    i_request = 1'b0;
    step();
    flush = 1'b0;
    compared++; if (mem_read !== 1'b1) begin mismatched++; $display("FAIL drop_mem_read_held: got %b expected 1", mem_read); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL drop_busy: got %b expected 1", busy); end
    respond(1, 32'h1111_1111, 1'b0);
    compared++; if (mem_read !== 1'b0) begin mismatched++; $display("FAIL drop_mem_read_end: got %b expected 0", mem_read); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL drop_busy_end: got %b expected 0", busy); end
    step();
    compared++; if (in_en_cnt !== base) begin mismatched++; $display("FAIL drop_no_in_en: got %0d pulses expected %0d", in_en_cnt, base); end

    i_request = 1'b1;
    pc_in     = 32'h200;
    exp_q.push_back('{32'h00A0_0113, 1'b0});
    step();
    compared++; if (mem_addr !== 32'h200) begin mismatched++; $display("FAIL after_flush_addr: got %h expected 200", mem_addr); end
    respond(0, 32'h00A0_0113, 1'b0);
    compared++; if (in_en !== 1'b1) begin mismatched++; $display("FAIL after_flush_in_en: got %b expected 1", in_en); end
    pop_exp(e);
    compared++; if (instruction !== e.instr) begin mismatched++; $display("FAIL after_flush_instr: got %h expected %h", instruction, e.instr); end
    i_request = 1'b0;
    step();

    base      = in_en_cnt;
    i_request = 1'b1;
    pc_in     = 32'h208;
    step();
    flush     = 1'b1;
    i_request = 1'b0;
    respond(0, 32'h2222_2222, 1'b0);
    flush = 1'b0;
    compared++; if ({in_en, mem_read, busy} !== 3'b000) begin mismatched++; $display("FAIL flush_ack_same: got %b expected 000", {in_en, mem_read, busy}); end
    compared++; if (instruction !== 32'h00A0_0113) begin mismatched++; $display("FAIL flush_ack_instr_held: got %h expected 00a00113", instruction); end
    step();
    compared++; if (in_en_cnt !== base) begin mismatched++; $display("FAIL flush_ack_no_in_en: got %0d pulses expected %0d", in_en_cnt, base); end
  endtask

  task automatic test_bus_error();
    exp_t e;
    i_request = 1'b1;
    pc_in     = 32'h204;
    exp_q.push_back('{NOP, 1'b1});
    step();
    respond(1, 32'h1234_5678, 1'b1);
    compared++; if (in_en !== 1'b1) begin mismatched++; $display("FAIL err_in_en: got %b expected 1", in_en); end
    pop_exp(e);
    compared++; if (instruction !== e.instr) begin mismatched++; $display("FAIL err_instr: got %h expected %h", instruction, e.instr); end
    compared++; if (fetch_fault !== e.fault) begin mismatched++; $display("FAIL err_fault: got %b expected %b", fetch_fault, e.fault); end
    i_request = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    i_request = 1'b1;
    pc_in     = 32'h400;
    exp_q.push_back('{32'h0010_0093, 1'b0});
    exp_q.push_back('{32'h0020_0113, 1'b0});
    step();
    respond(0, 32'h0010_0093, 1'b0);
    compared++; if (in_en !== 1'b1) begin mismatched++; $display("FAIL b2b_first_in_en: got %b expected 1", in_en); end
    pop_exp(e);
    compared++; if (instruction !== e.instr) begin mismatched++; $display("FAIL b2b_first_instr: got %h expected %h", instruction, e.instr); end
    pc_in = 32'h404;
    step();
    compared++; if ({mem_read, in_en} !== 2'b00) begin mismatched++; $display("FAIL b2b_gap: got %b expected 00", {mem_read, in_en}); end
    step();
    compared++; if (mem_read !== 1'b1) begin mismatched++; $display("FAIL b2b_second_read: got %b expected 1", mem_read); end
    compared++; if (mem_addr !== 32'h404) begin mismatched++; $display("FAIL b2b_second_addr: got %h expected 404", mem_addr); end
    respond(2, 32'h0020_0113, 1'b0);
    compared++; if (in_en !== 1'b1) begin mismatched++; $display("FAIL b2b_second_in_en: got %b expected 1", in_en); end
    pop_exp(e);
    compared++; if (instruction !== e.instr) begin mismatched++; $display("FAIL b2b_second_instr: got %h expected %h", instruction, e.instr); end
    i_request = 1'b0;
    step();
  endtask

  task automatic test_idle_inputs();
    exp_t e;
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    compared++; if ({in_en, busy} !== 2'b00) begin mismatched++; $display("FAIL idle_ack_ignored: got %b expected 00", {in_en, busy}); end
    compared++; if (instruction !== 32'h0020_0113) begin mismatched++; $display("FAIL idle_ack_instr: got %h expected 00200113", instruction); end
    i_request = 1'b1;
    pc_in     = 32'h600;
    flush     = 1'b1;
    step();
    compared++; if ({mem_read, busy} !== 2'b00) begin mismatched++; $display("FAIL idle_flush_suppress: got %b expected 00", {mem_read, busy}); end
    flush = 1'b0;
    exp_q.push_back('{32'h0060_0313, 1'b0});
    step();
    compared++; if (mem_read !== 1'b1) begin mismatched++; $display("FAIL idle_after_flush_read: got %b expected 1", mem_read); end
    respond(0, 32'h0060_0313, 1'b0);
    compared++; if (in_en !== 1'b1) begin mismatched++; $display("FAIL idle_after_flush_in_en: got %b expected 1", in_en); end
    pop_exp(e);
    compared++; if (instruction !== e.instr) begin mismatched++; $display("FAIL idle_after_flush_instr: got %h expected %h", instruction, e.instr); end
    i_request = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int base = in_en_cnt;
    i_request = 1'b1;
    pc_in     = 32'h500;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    compared++; if (mem_read !== 1'b0) begin mismatched++; $display("FAIL async_mem_read: got %b expected 0", mem_read); end
    compared++; if ({in_en, fetch_fault, busy} !== 3'b000) begin mismatched++; $display("FAIL async_flags: got %b expected 000", {in_en, fetch_fault, busy}); end
    compared++; if (instruction !== NOP) begin mismatched++; $display("FAIL async_instr: got %h expected %h", instruction, NOP); end
    compared++; if (mem_addr !== 32'h0) begin mismatched++; $display("FAIL async_mem_addr: got %h expected 0", mem_addr); end
    i_request = 1'b0;
    step();
    step();
    reset = 1'b0;
    repeat (3) step();
    compared++; if (in_en_cnt !== base) begin mismatched++; $display("FAIL async_no_in_en: got %0d pulses expected %0d", in_en_cnt, base); end
  endtask

  task automatic test_last_line();
    exp_t e;
    i_request = 1'b1;
    pc_in     = 32'h40;
    exp_q.push_back('{32'h0030_0193, 1'b0});
    step();
    respond(1, 32'h0030_0193, 1'b0);
    pop_exp(e);
    compared++; if (instruction !== e.instr) begin mismatched++; $display("FAIL line_first_instr: got %h expected %h", instruction, e.instr); end
    i_request = 1'b0;
    step();
    i_request = 1'b1;
`ifdef FETCH_LAST_LINE_EN
    exp_q.push_back('{32'h0030_0193, 1'b0});
    step();
    compared++; if ({in_en, mem_read} !== 2'b10) begin mismatched++; $display("FAIL line_hit: got in_en,mem_read=%b expected 10", {in_en, mem_read}); end
    pop_exp(e);
    compared++; if (instruction !== e.instr) begin mismatched++; $display("FAIL line_hit_instr: got %h expected %h", instruction, e.instr); end
    i_request = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush     = 1'b0;
    i_request = 1'b1;
`endif
    exp_q.push_back('{32'h0040_0213, 1'b0});
    step();
    compared++; if ({in_en, mem_read} !== 2'b01) begin mismatched++; $display("FAIL line_bus_access: got in_en,mem_read=%b expected 01", {in_en, mem_read}); end
    respond(0, 32'h0040_0213, 1'b0);
    pop_exp(e);
    compared++; if (instruction !== e.instr) begin mismatched++; $display("FAIL line_bus_instr: got %h expected %h", instruction, e.instr); end
    i_request = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_misaligned();
    test_timeout();
    test_flush();
    test_bus_error();
    test_back_to_back();
    test_idle_inputs();
    test_reset_mid();
    test_last_line();
    compared++; if (exp_q.size() !== 0) begin mismatched++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
